// File: rtl/axis_skid_fifo.sv
// -----------------------------------------------------------------------------
// axis_skid_fifo
//
// DEPTH-entry elastic buffer for a valid/ready stream. Every handshake output
// is decoded from registers only. There is no combinational path from i_valid
// or o_ready to any output, so the producer and consumer sides are fully
// decoupled in timing. The buffer absorbs bursts of backpressure, reports its
// occupancy and an almost-full flag, and supports a synchronous flush.
//
// Parameters
//   WIDTH        payload width in bits (>= 1)
//   DEPTH        number of entries, a power of two (>= 2)
//   AFULL_LEVEL  occupancy at or above which o_almost_full asserts (1..DEPTH)
//
// Ports
//   aclk           in   clock, rising edge
//   aresetn        in   asynchronous active-low reset
//   i_valid        in   upstream beat valid
//   i_data         in   upstream payload [WIDTH-1:0]
//   i_ready        out  buffer can accept a beat (not full)
//   o_valid        out  downstream beat valid (not empty)
//   o_data         out  downstream payload [WIDTH-1:0], the head entry
//   o_ready        in   downstream accepts the beat
//   i_flush        in   synchronous clear of all stored beats
//   o_count        out  occupancy 0..DEPTH [$clog2(DEPTH):0]
//   o_almost_full  out  o_count >= AFULL_LEVEL
//   i_last         in   end-of-packet marker (only with SKID_FIFO_LAST_EN)
//   o_last         out  head entry's end-of-packet marker (only with
//                       SKID_FIFO_LAST_EN)
//
// Build option
//   SKID_FIFO_LAST_EN  When defined, each entry carries an extra last bit
//                      alongside the payload.
// -----------------------------------------------------------------------------
module axis_skid_fifo #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     i_valid,
   input  logic [WIDTH-1:0]         i_data,
   output logic                     i_ready,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   input  logic                     o_ready,
`ifdef SKID_FIFO_LAST_EN
   input  logic                     i_last,
   output logic                     o_last,
`endif
   input  logic                     i_flush,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_almost_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef SKID_FIFO_LAST_EN
   localparam int unsigned EW = WIDTH + 1;
`else
   localparam int unsigned EW = WIDTH;
`endif

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [EW-1:0] entry_in;
   logic [EW-1:0] head;
   logic          push;
   logic          pop;

   // Handshake outputs are pure decodes of the registered count, so there
   // is no ready pass-through when full and no bypass when empty.
   assign i_ready       = (count != CW'(DEPTH));
   assign o_valid       = (count != '0);
   assign o_count       = count;
   assign o_almost_full = (count >= CW'(AFULL_LEVEL));

   assign push = i_valid & i_ready;
   assign pop  = o_valid & o_ready;

`ifdef SKID_FIFO_LAST_EN
   assign entry_in = {i_last, i_data};
`else
   assign entry_in = i_data;
`endif

   assign head   = mem[rd_ptr];
   assign o_data = head[WIDTH-1:0];
`ifdef SKID_FIFO_LAST_EN
   assign o_last = head[WIDTH];
`endif

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_nxt = count;
      unique case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so that all flops sample their old values on the same edge.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         // Flush beats push and pop; a beat offered this cycle is dropped.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   // NOTE: storage is reset so that o_data reads 0 straight out of reset; a flush leaves the contents as they are.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (push && !i_flush) begin
         mem[wr_ptr] <= entry_in;
      end
   end

endmodule
